// File: rtl/arbiter_xfer_pkg.sv
// Shared definitions for the arbiter transfer stage: state encoding,
// a constant clog2 and one-hot helpers used for port indices.
package arbiter_xfer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        XFER    = 2'd1,
        RELEASE = 2'd2
    } xfer_state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

    function automatic int oh_idx(input logic [31:0] v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) begin
                r = i;
            end
        end
        return r;
    endfunction

    function automatic logic is_onehot(input logic [31:0] v);
        return (v != '0) && ((v & (v - 32'd1)) == '0);
    endfunction

endpackage

// File: rtl/xfer_skid.sv
// Two-entry valid/ready skid buffer with fully registered outputs.
// in_ready_o is registered from the post-update occupancy.
module xfer_skid #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    logic [1:0]   cnt_q, cnt_d;
    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic         rdy_q, rdy_d;
    logic         push, pop;

    assign push = in_valid_i & rdy_q;
    assign pop  = (cnt_q != 2'd0) & out_ready_i;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q + 2'(push) - 2'(pop);
        // Pop frees the head slot before the incoming beat lands.
        if (pop && cnt_q == 2'd2) begin
            head_d = tail_q;
        end else if (push && (cnt_q == 2'd0 || pop)) begin
            head_d = in_data_i;
        end
        if (push && !pop && cnt_q == 2'd1) begin
            tail_d = in_data_i;
        end else if (push && pop && cnt_q == 2'd2) begin
            tail_d = in_data_i;
        end
        rdy_d = (cnt_d != 2'd2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= 2'd0;
            head_q <= '0;
            tail_q <= '0;
            rdy_q  <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            head_q <= head_d;
            tail_q <= tail_d;
            rdy_q  <= rdy_d;
        end
    end

    assign in_ready_o  = rdy_q;
    assign out_valid_o = (cnt_q != 2'd0);
    assign out_data_o  = head_q;

endmodule

// File: rtl/arbiter_xfer.sv
// Forwards the granted actor's packet beats onto one shared stream,
// limiting beats per grant and holding off across the grant lag.
module arbiter_xfer
    import arbiter_xfer_pkg::*;
#(
    parameter int NUM_PORTS  = 6,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BEATS  = 16,
    localparam int PORT_W =
        (clog2(NUM_PORTS) < 1) ? 1 : clog2(NUM_PORTS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [0:NUM_PORTS-1]            grant,
    input  logic                            active,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] up_data,
    input  logic [0:NUM_PORTS-1]            up_valid,
    input  logic [0:NUM_PORTS-1]            up_last,
    output logic [0:NUM_PORTS-1]            up_ready,
    output logic [DATA_WIDTH-1:0]           down_data,
    output logic [PORT_W-1:0]               down_port,
    output logic                            down_last,
    output logic                            down_valid,
    input  logic                            down_ready,
    output logic                            err
);

    localparam int CNT_W = clog2(MAX_BEATS + 1);
    localparam int SW    = DATA_WIDTH + PORT_W + 1;

    xfer_state_e       state_q, state_d;
    logic [PORT_W-1:0] sel_q, sel_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic              err_q, err_d;

    logic [31:0]           gvec;
    logic                  gsel, vsel, lsel;
    logic [DATA_WIDTH-1:0] dsel;
    logic                  xfer, acc, hit_max;
    logic                  sk_ready;
    logic [SW-1:0]         push_data, pop_data;

    always_comb begin
        gvec = '0;
        gsel = 1'b0;
        vsel = 1'b0;
        lsel = 1'b0;
        dsel = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            gvec[i] = grant[i];
            if (sel_q == PORT_W'(i)) begin
                gsel = grant[i];
                vsel = up_valid[i];
                lsel = up_last[i];
                dsel = up_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign xfer = (state_q == XFER);
    assign acc  = xfer & gsel & sk_ready & vsel;

    always_comb begin
        up_ready = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (sel_q == PORT_W'(i)) begin
                up_ready[i] = xfer & grant[i] & sk_ready;
            end
        end
    end

    // Saturating count so an overlong packet can never wrap.
    assign cnt_inc = (cnt_q == CNT_W'(MAX_BEATS)) ?
                     cnt_q : cnt_q + 1'b1;
    assign hit_max = (cnt_inc == CNT_W'(MAX_BEATS));

    assign push_data = {dsel, sel_q, lsel | hit_max};

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (active) begin
                    if (is_onehot(gvec)) begin
                        sel_d   = PORT_W'(oh_idx(gvec));
                        cnt_d   = '0;
                        state_d = XFER;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            XFER: begin
                if (!gsel) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (acc) begin
                    cnt_d = cnt_inc;
                    if (lsel) begin
                        state_d = RELEASE;
                    end else if (hit_max) begin
                        err_d   = 1'b1;
                        state_d = RELEASE;
                    end
                end
            end
            RELEASE: begin
                if (!gsel) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    xfer_skid #(
        .W(SW)
    ) u_skid (
        .clk        (clk),
        .rst_n      (rst),
        .in_valid_i (acc),
        .in_ready_o (sk_ready),
        .in_data_i  (push_data),
        .out_valid_o(down_valid),
        .out_ready_i(down_ready),
        .out_data_o (pop_data)
    );

    assign {down_data, down_port, down_last} = pop_data;
    assign err = err_q;

endmodule

// File: tb/tb_arbiter_xfer.sv
// Bench for arbiter_xfer: cycle table, corner sequences and a
// randomized packet run checked against a packet-level model.
module tb_arbiter_xfer;

    localparam int NP = 6;
    localparam int DW = 32;
    localparam int MB = 4;

    logic            clk;
    logic            rst;
    logic [0:NP-1]   grant;
    logic            active;
    logic [NP*DW-1:0] up_data;
    logic [0:NP-1]   up_valid;
    logic [0:NP-1]   up_last;
    logic [0:NP-1]   up_ready;
    logic [DW-1:0]   down_data;
    logic [2:0]      down_port;
    logic            down_last;
    logic            down_valid;
    logic            down_ready;
    logic            err;

    arbiter_xfer #(
        .NUM_PORTS (NP),
        .DATA_WIDTH(DW),
        .MAX_BEATS (MB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .grant     (grant),
        .active    (active),
        .up_data   (up_data),
        .up_valid  (up_valid),
        .up_last   (up_last),
        .up_ready  (up_ready),
        .down_data (down_data),
        .down_port (down_port),
        .down_last (down_last),
        .down_valid(down_valid),
        .down_ready(down_ready),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int          gp;
        bit          vld;
        bit          lst;
        logic [31:0] dat;
        bit          dr;
        bit          eur;
        bit          edv;
        logic [31:0] edd;
        bit          edl;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic [2:0]  p;
        logic        l;
    } beat_t;

    beat_t expq[$];
    bit    mon_en = 1'b0;
    int    err_seen = 0;
    logic  pv = 1'b0, pr = 1'b0, pl = 1'b0;
    logic [31:0] pd = '0;
    logic [2:0]  pp = '0;

    task automatic chk(input string nm, input logic [63:0] a,
                       input logic [63:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, a, e);
        end
    endtask

    function automatic logic [0:NP-1] urv(input int p);
        logic [0:NP-1] r;
        r = '0;
        if (p >= 0) r[p] = 1'b1;
        return r;
    endfunction

    task automatic drive(input int p, input bit v, input bit l,
                         input logic [31:0] d);
        grant    = urv(p);
        active   = (p >= 0);
        up_valid = '0;
        up_last  = '0;
        up_data  = '0;
        if (p >= 0) begin
            up_valid[p]       = v;
            up_last[p]        = l;
            up_data[p*DW +: DW] = d;
        end
    endtask

    task automatic hand(input int p, input int gcyc, input int nb,
                        input logic [31:0] base, input int ncyc,
                        output int acc, output int dn,
                        output int errs, output int nlast,
                        output int lastpos, output int bad);
        int k;
        int g;
        k = 0; acc = 0; dn = 0; errs = 0;
        nlast = 0; lastpos = -1; bad = 0;
        down_ready = 1'b1;
        for (int i = 0; i < ncyc; i++) begin
            g = (i < gcyc) ? p : -1;
            drive(g, 1'b1, (k == nb - 1), base + k);
            @(negedge clk);
            if (g >= 0 && up_ready[p]) begin
                acc++;
                k++;
            end
            if (down_valid) begin
                if (down_data !== base + dn || down_port !== p)
                    bad++;
                if (down_last) begin
                    nlast++;
                    lastpos = dn;
                end
                dn++;
            end
            if (err) errs++;
            @(posedge clk); #1;
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && rst) begin
            tests++;
            if ($countones(up_ready) > 1) begin
                fails++;
                $display("FAIL ur_onehot: got %b, expected <=1 bit",
                         up_ready);
            end
            if (pv && !pr) begin
                tests++;
                if (!down_valid || down_data !== pd ||
                    down_port !== pp || down_last !== pl) begin
                    fails++;
                    $display("FAIL hold: got v=%b d=%0h, expected v=1 d=%0h",
                             down_valid, down_data, pd);
                end
            end
            if (down_valid && down_ready) begin
                tests++;
                if (expq.size() == 0) begin
                    fails++;
                    $display("FAIL extra_beat: got %0h, expected none",
                             down_data);
                end else begin
                    beat_t e;
                    e = expq.pop_front();
                    if (down_data !== e.d || down_port !== e.p ||
                        down_last !== e.l) begin
                        fails++;
                        $display("FAIL beat: got %0h/%0d/%b, expected %0h/%0d/%b",
                                 down_data, down_port, down_last,
                                 e.d, e.p, e.l);
                    end
                end
            end
            if (err) err_seen++;
            pv = down_valid;
            pr = down_ready;
            pd = down_data;
            pp = down_port;
            pl = down_last;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    vec_t tbl[17];
    int acc, dn, errs, nlast, lastpos, bad;
    int exp_err;
    bit hold, stop;

    initial begin
        tbl[0]  = '{2, 1, 0, 32'hA0, 1, 0, 0, 0, 0};
        tbl[1]  = '{2, 1, 0, 32'hA0, 1, 1, 0, 0, 0};
        tbl[2]  = '{2, 1, 0, 32'hA1, 1, 1, 1, 32'hA0, 0};
        tbl[3]  = '{2, 1, 1, 32'hA2, 1, 1, 1, 32'hA1, 0};
        tbl[4]  = '{2, 0, 0, 32'h0,  1, 0, 1, 32'hA2, 1};
        tbl[5]  = '{-1, 0, 0, 32'h0, 1, 0, 0, 0, 0};
        tbl[6]  = '{-1, 0, 0, 32'h0, 1, 0, 0, 0, 0};
        tbl[7]  = '{2, 1, 0, 32'hA0, 0, 0, 0, 0, 0};
        tbl[8]  = '{2, 1, 0, 32'hA0, 0, 1, 0, 0, 0};
        tbl[9]  = '{2, 1, 0, 32'hA1, 0, 1, 1, 32'hA0, 0};
        tbl[10] = '{2, 1, 1, 32'hA2, 0, 0, 1, 32'hA0, 0};
        tbl[11] = '{2, 1, 1, 32'hA2, 0, 0, 1, 32'hA0, 0};
        tbl[12] = '{2, 1, 1, 32'hA2, 0, 0, 1, 32'hA0, 0};
        tbl[13] = '{2, 1, 1, 32'hA2, 1, 0, 1, 32'hA0, 0};
        tbl[14] = '{2, 1, 1, 32'hA2, 1, 1, 1, 32'hA1, 0};
        tbl[15] = '{2, 0, 0, 32'h0,  1, 0, 1, 32'hA2, 1};
        tbl[16] = '{-1, 0, 0, 32'h0, 1, 0, 0, 0, 0};

        rst = 1'b0;
        drive(-1, 0, 0, 0);
        down_ready = 1'b0;
        @(negedge clk);
        chk("rst_ur", up_ready, urv(-1));
        chk("rst_dv", down_valid, 0);
        chk("rst_dd", down_data, 0);
        chk("rst_dp", down_port, 0);
        chk("rst_dl", down_last, 0);
        chk("rst_err", err, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].gp, tbl[i].vld, tbl[i].lst, tbl[i].dat);
            down_ready = tbl[i].dr;
            @(negedge clk);
            chk($sformatf("t%0d_ur", i), up_ready,
                urv(tbl[i].eur ? 2 : -1));
            chk($sformatf("t%0d_dv", i), down_valid, tbl[i].edv);
            if (tbl[i].edv) begin
                chk($sformatf("t%0d_dd", i), down_data, tbl[i].edd);
                chk($sformatf("t%0d_dl", i), down_last, tbl[i].edl);
                chk($sformatf("t%0d_dp", i), down_port, 2);
            end
            chk($sformatf("t%0d_err", i), err, 0);
            @(posedge clk); #1;
        end

        // Release lag: grant[1] lingers one cycle after the last beat.
        down_ready = 1'b1;
        drive(1, 1, 1, 32'h11);
        @(negedge clk);
        chk("lag_ur0", up_ready, urv(-1));
        @(posedge clk); #1;
        @(negedge clk);
        chk("lag_ur1", up_ready, urv(1));
        @(posedge clk); #1;
        drive(1, 1, 0, 32'h12);
        @(negedge clk);
        chk("lag_ur_blk", up_ready, urv(-1));
        chk("lag_dd", down_data, 32'h11);
        chk("lag_dp", down_port, 1);
        chk("lag_dl", down_last, 1);
        @(posedge clk); #1;
        drive(3, 1, 1, 32'h33);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("lag3_ur_wait", up_ready, urv(-1));
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("lag3_ur", up_ready, urv(3));
        @(posedge clk); #1;
        drive(-1, 0, 0, 0);
        @(negedge clk);
        chk("lag3_dv", down_valid, 1);
        chk("lag3_dd", down_data, 32'h33);
        chk("lag3_dp", down_port, 3);
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Overlong packet on port 0: no last is ever offered.
        hand(0, 14, 1000, 32'hB0, 14, acc, dn, errs, nlast, lastpos, bad);
        chk("ovl_acc", acc, MB);
        chk("ovl_dn", dn, MB);
        chk("ovl_err", errs, 1);
        chk("ovl_nlast", nlast, 1);
        chk("ovl_lastpos", lastpos, MB - 1);
        chk("ovl_bad", bad, 0);
        @(negedge clk);
        chk("ovl_ur_after", up_ready, urv(-1));
        @(posedge clk); #1;
        drive(-1, 0, 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Grant loss after one of three beats, then a clean packet.
        hand(4, 2, 3, 32'hC0, 8, acc, dn, errs, nlast, lastpos, bad);
        chk("gl_acc", acc, 1);
        chk("gl_dn", dn, 1);
        chk("gl_err", errs, 1);
        chk("gl_nlast", nlast, 0);
        chk("gl_bad", bad, 0);
        hand(4, 4, 1, 32'hC8, 8, acc, dn, errs, nlast, lastpos, bad);
        chk("gl2_acc", acc, 1);
        chk("gl2_dn", dn, 1);
        chk("gl2_err", errs, 0);
        chk("gl2_nlast", nlast, 1);
        chk("gl2_bad", bad, 0);

        // Asynchronous reset in the middle of a stalled packet.
        drive(2, 1, 0, 32'hD0);
        down_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("ar_dv_pre", down_valid, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_dv", down_valid, 0);
        chk("ar_ur", up_ready, urv(-1));
        chk("ar_dd", down_data, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        hand(2, 4, 1, 32'hE0, 8, acc, dn, errs, nlast, lastpos, bad);
        chk("ar_acc", acc, 1);
        chk("ar_dn", dn, 1);
        chk("ar_bad", bad, 0);
        chk("ar_nlast", nlast, 1);

        // Randomized packets against a packet-level model.
        mon_en  = 1'b1;
        exp_err = 0;
        stop    = 1'b0;
        for (int n = 0; n < 300 && !stop; n++) begin
            int p, L, ne, k, t;
            logic [31:0] beats[6];
            p  = $urandom_range(0, NP - 1);
            L  = $urandom_range(1, 6);
            ne = (L > MB) ? MB : L;
            for (int j = 0; j < 6; j++) beats[j] = $urandom;
            for (int j = 0; j < ne; j++)
                expq.push_back('{beats[j], 3'(p), (j == ne - 1)});
            if (L > MB) exp_err++;
            k = 0; t = 0; hold = 1'b0;
            while (k < ne && t < 300) begin
                drive(p, hold || ($urandom_range(0, 3) != 0),
                      (k == L - 1), beats[k]);
                for (int i = 0; i < NP; i++) begin
                    if (i != p) begin
                        up_valid[i] = 1'($urandom_range(0, 1));
                        up_last[i]  = 1'($urandom_range(0, 1));
                        up_data[i*DW +: DW] = $urandom;
                    end
                end
                down_ready = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                hold = up_valid[p] && !up_ready[p];
                if (up_valid[p] && up_ready[p]) k++;
                t++;
                @(posedge clk); #1;
            end
            if (k < ne) begin
                fails++;
                $display("FAIL rand_timeout: got %0d beats, expected %0d",
                         k, ne);
                stop = 1'b1;
            end
            drive(p, 1, 0, $urandom);
            down_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            chk("rand_lag_ur", up_ready, urv(-1));
            @(posedge clk); #1;
            drive(-1, 0, 0, 0);
            @(posedge clk); #1;
        end
        down_ready = 1'b1;
        drive(-1, 0, 0, 0);
        for (int i = 0; i < 50 && expq.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rand_drain", expq.size(), 0);
        chk("rand_err", err_seen, exp_err);
        mon_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
